tdm_dec_fir_core: RTL and testbench
===================================

Name: tdm_dec_fir_core

Overview:
Parametrised successor to the single-channel fractional-decimator core. It is a time-division-multiplexed, N_CH-channel decimating FIR with addressed coefficient load and readback, run-time decimation factor, bypass, and sticky saturation flags. It sits at the head of the filter array, between the sample input interface and downstream rate-conversion stages.

Parameters:
DATA_WIDTH, 16, sample width, signed Q(DATA_WIDTH-DATA_FRAC).DATA_FRAC
DATA_FRAC, 15, sample fractional bits
COEFF_WIDTH, 20, coefficient width, signed
COEFF_FRAC, 18, coefficient fractional bits
N_TAP, 72, taps per channel; coefficients shared by all channels
N_CH, 4, interleaved channels, >=1
MAX_DEC, 8, largest decimation factor

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
valid_in  in  1  core_in holds a sample this cycle
core_in  in  DATA_WIDTH  sample; channels arrive strictly round-robin ch0..N_CH-1
dec_factor  in  clog2(MAX_DEC+1)  decimation factor; 0 treated as 1; values >MAX_DEC clamp to MAX_DEC
bypass  in  1  pass input to output unfiltered
coeff_wr_en  in  1  write coeff_wr_data to coeff_addr
coeff_addr  in  clog2(N_TAP)  tap index for write and readback
coeff_wr_data  in  COEFF_WIDTH  coefficient write data
coeff_rd_data  out  COEFF_WIDTH  registered readback of coeff[coeff_addr]
clear_flags  in  1  clears sticky flags
valid_out  out  1  core_out valid
core_out  out  DATA_WIDTH  filtered (or bypassed) sample
ch_out  out  max(1,clog2(N_CH))  channel of core_out
overflow  out  1  sticky: positive saturation occurred
underflow  out  1  sticky: negative saturation occurred

Behaviour:
- Reset: delay lines, coefficients, channel counter, phase counter, pipeline, core_out, ch_out, coeff_rd_data, valid_out, overflow, underflow all 0.
- Channel counter ch_cnt increments on each valid_in and wraps N_CH-1->0. A frame is N_CH samples.
- Phase counter ph increments at each frame end (valid_in with ch_cnt=N_CH-1) and wraps at dec_eff-1->0. dec_eff is captured from dec_factor only at a frame end when ph wraps to 0 (and at reset, where it is 1). Mid-frame changes to dec_factor are ignored until that point.
- Delay lines: on valid_in, x[ch_cnt][0]<=core_in and x[ch_cnt][k]<=x[ch_cnt][k-1]. Other channels are untouched. The delay lines and both counters keep updating while bypass is high.
- A sample produces output iff ph=0 when it is accepted, or bypass is high (bypass outputs every sample).
- Pipeline, latency 3 for both paths:
  - S1: delay-line write; tag {emit, ch, bypass, raw} registered.
  - S2: acc = sum over k of coeff[k]*x[ch][k], full precision with clog2(N_TAP) guard bits, registered.
  - S3: shift right by COEFF_FRAC (truncate toward -inf unless ROUND_EN), saturate to DATA_WIDTH, register to core_out.
  - valid_out is high in cycle t+3 for an emitting sample accepted in cycle t. Bypass outputs raw core_in.
  - Order is always preserved. Toggling bypass mid-stream never collides or drops in-flight outputs.
- Saturation: result > 2^(DATA_WIDTH-1)-1 outputs max and sets overflow; result < -2^(DATA_WIDTH-1) outputs min and sets underflow. Flags are never set in bypass.
- clear_flags clears both flags next edge. If a saturation event occurs in the same cycle as clear_flags, the flag ends up 1 (set wins).
- Coefficients: a write takes effect at the next edge and is used by any S2 computation in the following cycle onward. coeff_rd_data = coeff[coeff_addr] one cycle after the address is presented. Write and read of the same address in the same cycle returns the old value.
- valid_in low: no state change except coefficient write, flag clear, and pipeline advance.

Optional Feature:
ROUND_EN. Defined: add 2^(COEFF_FRAC-1) before the S3 shift (round-half-up); saturation applies after rounding. Undefined: plain arithmetic shift (truncation). Latency is 3 in both cases.

Test Plan:
- N_CH=1, dec_factor=1, coeff[0]=0x40000 (1.0), others 0, input 0x4000 then zeros -> core_out 0x4000 three cycles later, then 0x0000; no flags.
- N_CH=1, coeff[k]=0x10000 (0.25) for k=0..3, impulse 0x4000 -> four outputs of 0x1000 on consecutive valid samples, then 0.
- N_CH=2, dec_factor=3, continuous valid_in -> valid_out only for frames 0,3,6,… (two outputs per emitting frame, ch_out 0 then 1); change dec_factor to 2 mid-frame -> takes effect only after the current cycle of 3 frames completes.
- coeff[0]=0x7FFFF, all inputs 0x7FFF -> core_out 0x7FFF and overflow=1; inputs 0x8000 -> core_out 0x8000 and underflow=1; pulse clear_flags -> both 0.
- Toggle bypass every 5 samples with a ramp input -> output count and order match the emit rule; bypassed samples equal the input exactly; latency 3 throughout.
- Assert rst mid-stream -> all outputs 0 immediately; after release, the first output equals the filter applied to zero history.

Source files
------------

// File: rtl/tdm_dec_fir_core.sv
// Time-division-multiplexed N_CH-channel decimating FIR with shared coefficients, bypass and sticky saturation flags.
// Optional feature macro: ROUND_EN (round-half-up before the output shift instead of truncation).
module tdm_dec_fir_core #(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_FRAC   = 15,
  parameter int COEFF_WIDTH = 20,
  parameter int COEFF_FRAC  = 18,
  parameter int N_TAP       = 72,
  parameter int N_CH        = 4,
  parameter int MAX_DEC     = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  valid_in,
  input  logic [DATA_WIDTH-1:0]                 core_in,
  input  logic [$clog2(MAX_DEC+1)-1:0]          dec_factor,
  input  logic                                  bypass,
  input  logic                                  coeff_wr_en,
  input  logic [$clog2(N_TAP)-1:0]              coeff_addr,
  input  logic [COEFF_WIDTH-1:0]                coeff_wr_data,
  output logic [COEFF_WIDTH-1:0]                coeff_rd_data,
  input  logic                                  clear_flags,
  output logic                                  valid_out,
  output logic [DATA_WIDTH-1:0]                 core_out,
  output logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] ch_out,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int DEC_W = $clog2(MAX_DEC + 1);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAP);

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  if (DATA_FRAC >= DATA_WIDTH || N_CH < 1 || MAX_DEC < 1 || COEFF_FRAC < 1) begin : g_param_check
    $error("tdm_dec_fir_core: invalid parameter set");
  end

  logic signed [COEFF_WIDTH-1:0] coeff [N_TAP];
  logic signed [DATA_WIDTH-1:0]  x     [N_CH][N_TAP];

  logic [CH_W-1:0]  ch_cnt;
  logic [DEC_W-1:0] ph, dec_eff, dec_req;
  logic             frame_end, emit, addr_ok;

  logic                  s1_valid, s1_byp, s2_valid, s2_byp;
  logic [CH_W-1:0]       s1_ch, s2_ch;
  logic [DATA_WIDTH-1:0] s1_raw, s2_raw, sat_val;
  logic signed [ACC_W-1:0] acc_next, acc;
  logic signed [ACC_W:0]   rnd, shifted;
  logic                    pos_sat, neg_sat;

  // Requested factor after mapping 0 to 1 and clamping to MAX_DEC.
  always_comb begin
    dec_req = dec_factor;
    if (dec_factor == '0)
      dec_req = DEC_W'(1);
    else if (dec_factor > DEC_W'(MAX_DEC))
      dec_req = DEC_W'(MAX_DEC);
  end

  assign frame_end = valid_in && (ch_cnt == CH_W'(N_CH - 1));
  assign emit      = valid_in && ((ph == '0) || bypass);
  assign addr_ok   = int'(coeff_addr) < N_TAP;

  // The decimation factor only changes at a decimation-cycle boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt  <= '0;
      ph      <= '0;
      dec_eff <= DEC_W'(1);
    end else if (valid_in) begin
      ch_cnt <= frame_end ? '0 : ch_cnt + CH_W'(1);
      if (frame_end) begin
        if (ph >= dec_eff - DEC_W'(1)) begin
          ph      <= '0;
          dec_eff <= dec_req;
        end else begin
          ph <= ph + DEC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < N_TAP; k++)
          x[c][k] <= '0;
    end else if (valid_in) begin
      x[ch_cnt][0] <= core_in;
      for (int k = 1; k < N_TAP; k++)
        x[ch_cnt][k] <= x[ch_cnt][k-1];
    end
  end

  // Readback samples the array before any same-cycle write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_TAP; k++)
        coeff[k] <= '0;
      coeff_rd_data <= '0;
    end else begin
      if (coeff_wr_en && addr_ok)
        coeff[coeff_addr] <= coeff_wr_data;
      coeff_rd_data <= addr_ok ? coeff[coeff_addr] : '0;
    end
  end

  always_comb begin
    acc_next = '0;
    for (int k = 0; k < N_TAP; k++)
      acc_next = acc_next + ACC_W'(coeff[k]) * ACC_W'(x[s1_ch][k]);
  end

`ifdef ROUND_EN
  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (COEFF_FRAC - 1);
  assign rnd = (ACC_W + 1)'(acc) + HALF;
`else
  assign rnd = (ACC_W + 1)'(acc);
`endif

  assign shifted = rnd >>> COEFF_FRAC;
  assign pos_sat = shifted > SAT_MAX;
  assign neg_sat = shifted < SAT_MIN;

  always_comb begin
    sat_val = shifted[DATA_WIDTH-1:0];
    if (pos_sat)
      sat_val = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    else if (neg_sat)
      sat_val = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
  end

  // Both paths share one three-stage pipeline, so order is preserved across bypass toggles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_byp    <= 1'b0;
      s1_ch     <= '0;
      s1_raw    <= '0;
      s2_valid  <= 1'b0;
      s2_byp    <= 1'b0;
      s2_ch     <= '0;
      s2_raw    <= '0;
      acc       <= '0;
      valid_out <= 1'b0;
      core_out  <= '0;
      ch_out    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      s1_valid <= emit;
      s1_byp   <= bypass;
      s1_ch    <= ch_cnt;
      s1_raw   <= core_in;

      s2_valid <= s1_valid;
      s2_byp   <= s1_byp;
      s2_ch    <= s1_ch;
      s2_raw   <= s1_raw;
      if (s1_valid && !s1_byp)
        acc <= acc_next;

      valid_out <= s2_valid;
      if (s2_valid) begin
        ch_out   <= s2_ch;
        core_out <= s2_byp ? s2_raw : sat_val;
      end

      if (s2_valid && !s2_byp && pos_sat)
        overflow <= 1'b1;
      else if (clear_flags)
        overflow <= 1'b0;

      if (s2_valid && !s2_byp && neg_sat)
        underflow <= 1'b1;
      else if (clear_flags)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_dec_fir_core.sv
// Self-checking bench for tdm_dec_fir_core: directed and randomized stimulus against an arithmetic reference model.
module tb_tdm_dec_fir_core;

  localparam int DW   = 16;
  localparam int CWD  = 20;
  localparam int CF   = 18;
  localparam int NT   = 12;
  localparam int NC   = 2;
  localparam int MD   = 8;
  localparam int DECW = $clog2(MD + 1);
  localparam int AW   = $clog2(NT);
  localparam int CHW  = (NC > 1) ? $clog2(NC) : 1;
  localparam longint SMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (DW - 1));

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_in = 1'b0;
  logic [DW-1:0]   core_in = '0;
  logic [DECW-1:0] dec_factor = DECW'(1);
  logic            bypass = 1'b0;
  logic            coeff_wr_en = 1'b0;
  logic [AW-1:0]   coeff_addr = '0;
  logic [CWD-1:0]  coeff_wr_data = '0;
  logic [CWD-1:0]  coeff_rd_data;
  logic            clear_flags = 1'b0;
  logic            valid_out;
  logic [DW-1:0]   core_out;
  logic [CHW-1:0]  ch_out;
  logic            overflow, underflow;

  tdm_dec_fir_core #(
    .DATA_WIDTH(DW), .DATA_FRAC(15), .COEFF_WIDTH(CWD), .COEFF_FRAC(CF),
    .N_TAP(NT), .N_CH(NC), .MAX_DEC(MD)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .core_in(core_in),
    .dec_factor(dec_factor), .bypass(bypass), .coeff_wr_en(coeff_wr_en),
    .coeff_addr(coeff_addr), .coeff_wr_data(coeff_wr_data), .coeff_rd_data(coeff_rd_data),
    .clear_flags(clear_flags), .valid_out(valid_out), .core_out(core_out),
    .ch_out(ch_out), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           valid;
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
    logic           pos;
    logic           neg;
  } exp_t;

  exp_t   pipe_q[$];
  longint mcoeff [NT];
  longint hist   [NC][NT];
  int     m_ch, m_ph, m_dec;
  logic   m_ovf, m_unf;
  int     errors = 0;
  int     checks = 0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      mcoeff[k] = 0;
      for (int c = 0; c < NC; c++) hist[c][k] = 0;
    end
    m_ch = 0; m_ph = 0; m_dec = 1; m_ovf = 1'b0; m_unf = 1'b0;
    pipe_q = {};
    pipe_q.push_back('0);
    pipe_q.push_back('0);
  endtask

  // Filtered value from the definition: dot product, scale by 2^-CF, clip to the sample range.
  function automatic exp_t model_filter(input int ch, input logic byp, input logic [DW-1:0] raw);
    exp_t e;
    longint acc;
    e = '0;
    e.valid = 1'b1;
    e.ch = CHW'(ch);
    if (byp) begin
      e.data = raw;
    end else begin
      acc = 0;
      for (int k = 0; k < NT; k++) acc += mcoeff[k] * hist[ch][k];
`ifdef ROUND_EN
      acc += longint'(1) <<< (CF - 1);
`endif
      acc = acc >>> CF;
      if (acc > SMAX) begin
        e.data = DW'(SMAX); e.pos = 1'b1;
      end else if (acc < SMIN) begin
        e.data = DW'(SMIN); e.neg = 1'b1;
      end else begin
        e.data = DW'(acc);
      end
    end
    return e;
  endfunction

  // One clock: predict, advance, then compare the outputs on the falling edge.
  task automatic apply_stimulus();
    exp_t e, vis;
    logic [CWD-1:0] exp_rd;
    longint tmp;
    int dreq;
    tmp = mcoeff[coeff_addr];
    exp_rd = tmp[CWD-1:0];
    if (coeff_wr_en) mcoeff[coeff_addr] = longint'($signed(coeff_wr_data));
    e = '0;
    if (valid_in) begin
      for (int k = NT - 1; k > 0; k--) hist[m_ch][k] = hist[m_ch][k-1];
      hist[m_ch][0] = longint'($signed(core_in));
      if (m_ph == 0 || bypass) e = model_filter(m_ch, bypass, core_in);
      dreq = (dec_factor == 0) ? 1 : (int'(dec_factor) > MD) ? MD : int'(dec_factor);
      if (m_ch == NC - 1) begin
        if (m_ph == m_dec - 1) begin
          m_ph = 0; m_dec = dreq;
        end else begin
          m_ph++;
        end
      end
      m_ch = (m_ch + 1) % NC;
    end
    @(posedge clk);
    pipe_q.push_back(e);
    vis = pipe_q.pop_front();
    if (vis.valid && vis.pos) m_ovf = 1'b1;
    else if (clear_flags) m_ovf = 1'b0;
    if (vis.valid && vis.neg) m_unf = 1'b1;
    else if (clear_flags) m_unf = 1'b0;
    @(negedge clk);
    check_output("valid_out", valid_out, vis.valid);
    if (vis.valid) begin
      check_output("core_out", core_out, vis.data);
      check_output("ch_out", ch_out, vis.ch);
    end
    check_output("overflow", overflow, m_ovf);
    check_output("underflow", underflow, m_unf);
    check_output("coeff_rd_data", coeff_rd_data, exp_rd);
  endtask

  task automatic feed(input logic vin, input logic [DW-1:0] din);
    valid_in = vin;
    core_in = din;
    apply_stimulus();
    valid_in = 1'b0;
  endtask

  task automatic write_coeff(input int addr, input logic [CWD-1:0] data);
    coeff_addr = AW'(addr);
    coeff_wr_data = data;
    coeff_wr_en = 1'b1;
    apply_stimulus();
    coeff_wr_en = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_output("rst_valid_out", valid_out, 0);
    check_output("rst_core_out", core_out, 0);
    check_output("rst_ch_out", ch_out, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_underflow", underflow, 0);
    check_output("rst_coeff_rd_data", coeff_rd_data, 0);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    coeff_wr_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    $display("[TB] unity tap impulse");
    write_coeff(0, 20'h40000);
    feed(1'b1, 16'h4000);
    repeat (2 * NT) feed(1'b1, 16'h0000);
    repeat (4) apply_stimulus();

    $display("[TB] four quarter taps impulse");
    for (int k = 0; k < 4; k++) write_coeff(k, 20'h10000);
    feed(1'b1, 16'h4000);
    repeat (2 * NT) feed(1'b1, 16'h0000);
    repeat (4) apply_stimulus();

    $display("[TB] random taps, decimation 3 then 2 mid-frame");
    for (int k = 0; k < NT; k++) write_coeff(k, CWD'(int'($urandom_range(0, 65535)) - 32768));
    dec_factor = DECW'(3);
    repeat (13) feed(1'b1, DW'($urandom));
    dec_factor = DECW'(2);
    repeat (30) feed(1'b1, DW'($urandom));
    repeat (40) feed($urandom_range(0, 3) != 0, DW'($urandom));
    dec_factor = DECW'(0);
    repeat (20) feed(1'b1, DW'($urandom));
    dec_factor = DECW'(13);
    repeat (50) feed(1'b1, DW'($urandom));
    repeat (4) apply_stimulus();

    $display("[TB] saturation and sticky flags");
    dec_factor = DECW'(1);
    for (int k = 1; k < NT; k++) write_coeff(k, 20'h00000);
    write_coeff(0, 20'h7FFFF);
    repeat (4) feed(1'b1, 16'h7FFF);
    repeat (4) apply_stimulus();
    repeat (4) feed(1'b1, 16'h8000);
    repeat (4) apply_stimulus();
    clear_flags = 1'b1;
    apply_stimulus();
    clear_flags = 1'b0;
    repeat (2) apply_stimulus();
    clear_flags = 1'b1;
    repeat (6) feed(1'b1, 16'h7FFF);
    clear_flags = 1'b0;
    repeat (4) apply_stimulus();
    clear_flags = 1'b1;
    apply_stimulus();
    clear_flags = 1'b0;
    apply_stimulus();

    $display("[TB] bypass toggling with ramp");
    for (int k = 0; k < NT; k++) write_coeff(k, CWD'(int'($urandom_range(0, 65535)) - 32768));
    dec_factor = DECW'(3);
    for (int i = 0; i < 60; i++) begin
      bypass = ((i / 5) % 2) == 1;
      feed(1'b1, DW'(i * 257));
    end
    for (int i = 0; i < 40; i++) begin
      bypass = ((i / 5) % 2) == 0;
      feed($urandom_range(0, 2) != 0, DW'(16'h8000 + i * 3));
    end
    bypass = 1'b0;
    repeat (4) apply_stimulus();

    $display("[TB] reset mid-stream");
    dec_factor = DECW'(1);
    write_coeff(0, 20'h7FFFF);
    repeat (5) feed(1'b1, 16'h7FFF);
    do_reset();
    write_coeff(0, 20'h40000);
    write_coeff(1, 20'h20000);
    feed(1'b1, 16'h1234);
    feed(1'b1, 16'h0100);
    feed(1'b1, 16'h2000);
    repeat (4) apply_stimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
